// File: rtl/i2c_target_regs.sv
`timescale 1ns/1ps
// I2C target serving a 4-byte register bank through an auto-incrementing pointer.
// Bus events are seen 3-4 clk after the wire edge; SDA is only pulled low (open drain).
module i2c_target_regs #(
    parameter logic [6:0] ADDR = 7'h50
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i2c_scl,
    input  logic        i2c_sda,
    output logic        i2c_sda_oe,
    output logic [7:0]  data_out,
    output logic        data_valid,
    output logic [1:0]  reg_ptr,
    output logic [31:0] regs,
    output logic        busy
);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
        S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK
    } state_t;

    state_t          r_state, w_state_nxt;
    logic            r_scl_s1, r_scl_s2, r_scl_d;
    logic            r_sda_s1, r_sda_s2, r_sda_d;
    logic [3:0]      r_cnt;
    logic [6:0]      r_rx;
    logic [7:0]      r_tx;
    logic            r_rw, r_ack_ph, r_oe, r_busy, r_dv;
    logic [1:0]      r_ptr;
    logic [3:0][7:0] r_regs;
    logic [7:0]      r_data_out;
    logic            w_oe_nxt, w_busy_nxt;

    wire       w_scl_rise  = r_scl_s2 & ~r_scl_d;
    wire       w_scl_fall  = ~r_scl_s2 & r_scl_d;
    wire       w_start     = r_scl_s2 & r_scl_d & r_sda_d & ~r_sda_s2;
    wire       w_stop      = r_scl_s2 & r_scl_d & ~r_sda_d & r_sda_s2;
    wire [7:0] w_rx_byte   = {r_rx, r_sda_s2};
    wire       w_byte_done = w_scl_rise && (r_cnt == 4'd7);
    wire       w_addr_hit  = (w_rx_byte[7:1] == ADDR);
    wire [1:0] w_ptr_inc   = r_ptr + 2'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {r_scl_s1, r_scl_s2, r_scl_d} <= 3'b111;
            {r_sda_s1, r_sda_s2, r_sda_d} <= 3'b111;
            r_state <= S_IDLE;
        end else begin
            {r_scl_s1, r_scl_s2, r_scl_d} <= {i2c_scl, r_scl_s1, r_scl_s2};
            {r_sda_s1, r_sda_s2, r_sda_d} <= {i2c_sda, r_sda_s1, r_sda_s2};
            r_state <= w_state_nxt;
        end
    end

    // STOP outranks repeated START, which outranks any in-state progress.
    always_comb begin
        w_state_nxt = r_state;
        if (w_stop) begin
            w_state_nxt = S_IDLE;
        end else if (w_start) begin
            w_state_nxt = S_ADDR;
        end else begin
            case (r_state)
                S_ADDR:      if (w_byte_done) w_state_nxt = w_addr_hit ? S_ADDR_ACK : S_IDLE;
                S_ADDR_ACK:  if (w_scl_fall && r_ack_ph) w_state_nxt = r_rw ? S_RDATA : S_PTR;
                S_PTR:       if (w_byte_done) w_state_nxt = S_PTR_ACK;
                S_PTR_ACK:   if (w_scl_fall && r_ack_ph) w_state_nxt = S_WDATA;
                S_WDATA:     if (w_byte_done) w_state_nxt = S_WDATA_ACK;
                S_WDATA_ACK: if (w_scl_fall && r_ack_ph) w_state_nxt = S_WDATA;
                S_RDATA:     if (w_scl_fall && r_cnt == 4'd8) w_state_nxt = S_RDATA_ACK;
                S_RDATA_ACK: if (w_scl_rise) w_state_nxt = r_sda_s2 ? S_IDLE : S_RDATA;
                default:     w_state_nxt = S_IDLE;
            endcase
        end
    end

    // The ACK phase flag splits each 9th bit into "assert on first fall, release on second".
    always_comb begin
        w_oe_nxt = 1'b0;
        if (!(w_stop || w_start)) begin
            case (r_state)
                S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
                    w_oe_nxt = r_oe;
                    if (w_scl_fall) begin
                        if (!r_ack_ph)
                            w_oe_nxt = 1'b1;
                        else if (r_state == S_ADDR_ACK && r_rw)
                            w_oe_nxt = ~r_regs[r_ptr][7];
                        else
                            w_oe_nxt = 1'b0;
                    end
                end
                S_RDATA: begin
                    w_oe_nxt = r_oe;
                    if (w_scl_fall) begin
                        if (r_cnt == 4'd0)      w_oe_nxt = ~r_tx[7];
                        else if (r_cnt == 4'd8) w_oe_nxt = 1'b0;
                        else                    w_oe_nxt = ~r_tx[6];
                    end
                end
                default: w_oe_nxt = 1'b0;
            endcase
        end
        w_busy_nxt = r_busy;
        if (r_state == S_ADDR && w_byte_done && w_addr_hit) w_busy_nxt = 1'b1;
        if (w_state_nxt == S_IDLE) w_busy_nxt = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= 4'd0;
            r_rx       <= 7'd0;
            r_tx       <= 8'd0;
            r_rw       <= 1'b0;
            r_ack_ph   <= 1'b0;
            r_oe       <= 1'b0;
            r_busy     <= 1'b0;
            r_dv       <= 1'b0;
            r_ptr      <= 2'd0;
            r_regs     <= '0;
            r_data_out <= 8'd0;
        end else begin
            r_oe   <= w_oe_nxt;
            r_busy <= w_busy_nxt;
            r_dv   <= 1'b0;
            if (w_stop || w_start) begin
                r_cnt    <= 4'd0;
                r_ack_ph <= 1'b0;
            end else begin
                case (r_state)
                    S_ADDR, S_PTR, S_WDATA: begin
                        if (w_scl_rise) begin
                            r_rx  <= w_rx_byte[6:0];
                            r_cnt <= w_byte_done ? 4'd0 : r_cnt + 4'd1;
                        end
                        if (w_byte_done && r_state == S_ADDR) r_rw <= r_sda_s2;
                        if (w_byte_done && r_state == S_PTR) r_ptr <= w_rx_byte[1:0];
                        if (w_byte_done && r_state == S_WDATA) begin
                            r_regs[r_ptr] <= w_rx_byte;
                            r_data_out    <= w_rx_byte;
                            r_dv          <= 1'b1;
                            r_ptr         <= w_ptr_inc;
                        end
                    end
                    S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
                        if (w_scl_fall) begin
                            r_ack_ph <= ~r_ack_ph;
                            if (r_state == S_ADDR_ACK && r_ack_ph) r_tx <= r_regs[r_ptr];
                        end
                    end
                    S_RDATA: begin
                        if (w_scl_rise)
                            r_cnt <= r_cnt + 4'd1;
                        else if (w_scl_fall && r_cnt == 4'd8)
                            r_cnt <= 4'd0;
                        else if (w_scl_fall && r_cnt != 4'd0)
                            r_tx <= {r_tx[6:0], 1'b0};
                    end
                    S_RDATA_ACK: begin
                        if (w_scl_rise) begin
                            r_ptr <= w_ptr_inc;
                            r_tx  <= r_regs[w_ptr_inc];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign i2c_sda_oe = r_oe;
    assign data_out   = r_data_out;
    assign data_valid = r_dv;
    assign reg_ptr    = r_ptr;
    assign regs       = r_regs;
    assign busy       = r_busy;

endmodule

// File: tb/tb_i2c_target_regs.sv
`timescale 1ns/1ps
// Directed bench for i2c_target_regs: bit-banged master on a wired-AND SDA line.
module tb_i2c_target_regs;
    localparam int Q = 80;

    logic        clk = 1'b0, rst = 1'b1, m_scl = 1'b1, m_sda = 1'b1;
    logic        sda_oe, dv, bsy;
    logic [7:0]  dout;
    logic [1:0]  ptr;
    logic [31:0] regs;
    wire         sda_line;
    int          n_checks = 0, n_pass = 0, dv_cnt = 0;
    logic        oe_seen = 1'b0, busy_seen = 1'b0;

    assign sda_line = m_sda & ~sda_oe;

    i2c_target_regs dut (
        .clk(clk), .rst(rst), .i2c_scl(m_scl), .i2c_sda(sda_line),
        .i2c_sda_oe(sda_oe), .data_out(dout), .data_valid(dv),
        .reg_ptr(ptr), .regs(regs), .busy(bsy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (dv) dv_cnt++;
        if (sda_oe) oe_seen = 1'b1;
        if (bsy) busy_seen = 1'b1;
    end

    task automatic clr_mon();
        dv_cnt = 0; oe_seen = 1'b0; busy_seen = 1'b0;
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; #(Q); m_scl = 1'b1; #(Q); m_sda = 1'b0; #(Q); m_scl = 1'b0; #(Q);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; #(Q); m_scl = 1'b1; #(Q); m_sda = 1'b1; #(Q);
    endtask

    task automatic write_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            m_sda = b[i]; #(Q); m_scl = 1'b1; #(2*Q); m_scl = 1'b0; #(Q);
        end
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        write_bits(b, 8);
        m_sda = 1'b1; #(Q); m_scl = 1'b1; #(Q); ack = sda_line; #(Q); m_scl = 1'b0; #(Q);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] b);
        m_sda = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            #(Q); m_scl = 1'b1; #(Q); b[i] = sda_line; #(Q); m_scl = 1'b0;
        end
        #(Q); m_sda = mack; #(Q); m_scl = 1'b1; #(2*Q); m_scl = 1'b0; #(Q); m_sda = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks += 6;
        if (sda_oe !== 1'b0) $display("FAIL reset_oe: got %b want 0", sda_oe); else n_pass++;
        if (dout !== 8'h00) $display("FAIL reset_dout: got %h want 00", dout); else n_pass++;
        if (dv !== 1'b0) $display("FAIL reset_dv: got %b want 0", dv); else n_pass++;
        if (ptr !== 2'd0) $display("FAIL reset_ptr: got %0d want 0", ptr); else n_pass++;
        if (regs !== 32'h0) $display("FAIL reset_regs: got %h want 00000000", regs); else n_pass++;
        if (bsy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bsy); else n_pass++;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_write_burst(input string tag);
        logic a0, a1, a2, a3;
        clr_mon();
        i2c_start();
        write_byte(8'hA0, a0); write_byte(8'h01, a1); write_byte(8'h5A, a2); write_byte(8'hC3, a3);
        n_checks++;
        if (bsy !== 1'b1) $display("FAIL %s busy_in_xfer: got %b want 1", tag, bsy); else n_pass++;
        i2c_stop();
        #(Q);
        n_checks += 6;
        if ({a0, a1, a2, a3} !== 4'b0000) $display("FAIL %s acks: got %b want 0000", tag, {a0, a1, a2, a3}); else n_pass++;
        if (regs !== 32'h00C35A00) $display("FAIL %s regs: got %h want 00C35A00", tag, regs); else n_pass++;
        if (ptr !== 2'd3) $display("FAIL %s ptr: got %0d want 3", tag, ptr); else n_pass++;
        if (dout !== 8'hC3) $display("FAIL %s dout: got %h want C3", tag, dout); else n_pass++;
        if (dv_cnt !== 2) $display("FAIL %s dv_pulses: got %0d want 2", tag, dv_cnt); else n_pass++;
        if (bsy !== 1'b0) $display("FAIL %s busy_after_stop: got %b want 0", tag, bsy); else n_pass++;
    endtask

    task automatic test_read_rs();
        logic a0, a1, a2;
        logic [7:0] b0, b1;
        clr_mon();
        i2c_start();
        write_byte(8'hA0, a0); write_byte(8'h01, a1);
        i2c_start();
        write_byte(8'hA1, a2);
        read_byte(1'b0, b0);
        read_byte(1'b1, b1);
        @(negedge clk);
        n_checks += 4;
        if (ptr !== 2'd3) $display("FAIL read_ptr: got %0d want 3", ptr); else n_pass++;
        if (sda_oe !== 1'b0) $display("FAIL read_oe_after_nack: got %b want 0", sda_oe); else n_pass++;
        if (b0 !== 8'h5A) $display("FAIL read_byte0: got %h want 5A", b0); else n_pass++;
        if (b1 !== 8'hC3) $display("FAIL read_byte1: got %h want C3", b1); else n_pass++;
        i2c_stop();
        #(Q);
        n_checks += 3;
        if ({a0, a1, a2} !== 3'b000) $display("FAIL read_acks: got %b want 000", {a0, a1, a2}); else n_pass++;
        if (dv_cnt !== 0) $display("FAIL read_dv: got %0d want 0", dv_cnt); else n_pass++;
        if (bsy !== 1'b0) $display("FAIL read_busy: got %b want 0", bsy); else n_pass++;
    endtask

    task automatic test_mismatch();
        logic a0, a1;
        clr_mon();
        i2c_start();
        write_byte(8'hA2, a0); write_byte(8'h00, a1);
        i2c_stop();
        #(Q);
        n_checks += 6;
        if (a0 !== 1'b1) $display("FAIL mis_addr_nack: got %b want 1", a0); else n_pass++;
        if (a1 !== 1'b1) $display("FAIL mis_data_nack: got %b want 1", a1); else n_pass++;
        if (oe_seen !== 1'b0) $display("FAIL mis_oe_seen: got %b want 0", oe_seen); else n_pass++;
        if (busy_seen !== 1'b0) $display("FAIL mis_busy_seen: got %b want 0", busy_seen); else n_pass++;
        if (regs !== 32'h00C35A00) $display("FAIL mis_regs: got %h want 00C35A00", regs); else n_pass++;
        if (dv_cnt !== 0) $display("FAIL mis_dv: got %0d want 0", dv_cnt); else n_pass++;
    endtask

    task automatic test_ptr_wrap();
        logic a;
        clr_mon();
        i2c_start();
        write_byte(8'hA0, a); write_byte(8'h03, a); write_byte(8'h11, a); write_byte(8'h22, a);
        i2c_stop();
        #(Q);
        n_checks += 3;
        if (regs !== 32'h11C35A22) $display("FAIL wrap_regs: got %h want 11C35A22", regs); else n_pass++;
        if (ptr !== 2'd1) $display("FAIL wrap_ptr: got %0d want 1", ptr); else n_pass++;
        if (dv_cnt !== 2) $display("FAIL wrap_dv: got %0d want 2", dv_cnt); else n_pass++;
        i2c_start();
        write_byte(8'hA0, a); write_byte(8'hFF, a);
        i2c_stop();
        #(Q);
        n_checks++;
        if (ptr !== 2'd3) $display("FAIL wrap_ptr_ff: got %0d want 3", ptr); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic a;
        i2c_start();
        write_byte(8'hA0, a); write_byte(8'h00, a);
        write_bits(8'hA5, 4);
        rst = 1'b1;
        #2;
        n_checks += 6;
        if (sda_oe !== 1'b0) $display("FAIL rmid_oe: got %b want 0", sda_oe); else n_pass++;
        if (regs !== 32'h0) $display("FAIL rmid_regs: got %h want 00000000", regs); else n_pass++;
        if (ptr !== 2'd0) $display("FAIL rmid_ptr: got %0d want 0", ptr); else n_pass++;
        if (dout !== 8'h00) $display("FAIL rmid_dout: got %h want 00", dout); else n_pass++;
        if (bsy !== 1'b0) $display("FAIL rmid_busy: got %b want 0", bsy); else n_pass++;
        if (dv !== 1'b0) $display("FAIL rmid_dv: got %b want 0", dv); else n_pass++;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (sda_oe !== 1'b0) $display("FAIL rmid_oe_held: got %b want 0", sda_oe); else n_pass++;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        test_write_burst("after_reset");
    endtask

    task automatic test_stop_mid();
        logic a;
        clr_mon();
        i2c_start();
        write_byte(8'hA0, a); write_byte(8'h00, a);
        write_bits(8'hE0, 3);
        i2c_stop();
        #(Q);
        n_checks += 5;
        if (dv_cnt !== 0) $display("FAIL smid_dv: got %0d want 0", dv_cnt); else n_pass++;
        if (regs !== 32'h00C35A00) $display("FAIL smid_regs: got %h want 00C35A00", regs); else n_pass++;
        if (bsy !== 1'b0) $display("FAIL smid_busy: got %b want 0", bsy); else n_pass++;
        if (sda_oe !== 1'b0) $display("FAIL smid_oe: got %b want 0", sda_oe); else n_pass++;
        if (ptr !== 2'd0) $display("FAIL smid_ptr: got %0d want 0", ptr); else n_pass++;
        i2c_start();
        write_byte(8'hA0, a); write_byte(8'h02, a); write_byte(8'h77, a);
        i2c_stop();
        #(Q);
        n_checks += 2;
        if (regs !== 32'h00775A00) $display("FAIL smid_recover_regs: got %h want 00775A00", regs); else n_pass++;
        if (dv_cnt !== 1) $display("FAIL smid_recover_dv: got %0d want 1", dv_cnt); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_write_burst("burst");
        test_read_rs();
        test_mismatch();
        test_ptr_wrap();
        test_reset_mid();
        test_stop_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
